// File: rtl/rob_commit_controller.sv
// In-order retirement sequencer for the reorder buffer head, with a
// flush/redirect sequence on exception, interrupt or trap entries.
module rob_commit_controller #(
    parameter int Q_WIDTH   = 4,
    parameter int Q_DEPTH   = 64,
    parameter int ADDR_BITS = 64,
    parameter logic [ADDR_BITS-1:0] EXC_VECTOR  = 64'h100,
    parameter logic [ADDR_BITS-1:0] INT_VECTOR  = 64'h200,
    parameter logic [ADDR_BITS-1:0] TRAP_VECTOR = 64'h300
) (
    input  logic                                  clk_in,
    input  logic                                  rst_N_in,
    input  logic [$clog2(Q_DEPTH+1)-1:0]          rob_size_in,
    input  logic [Q_WIDTH*3-1:0]                  head_status_in,
    input  logic [Q_WIDTH-1:0]                    head_is_store_in,
    input  logic [Q_WIDTH*ADDR_BITS-1:0]          head_pc_in,
    input  logic                                  st_commit_ready_in,
    output logic [$clog2(Q_WIDTH+1)-1:0]          deq_out,
    output logic [Q_WIDTH-1:0]                    commit_mask_out,
    output logic                                  st_commit_valid_out,
    output logic [$clog2(Q_WIDTH)-1:0]            st_commit_slot_out,
    output logic                                  flush_out,
    output logic                                  redirect_valid_out,
    output logic [ADDR_BITS-1:0]                  redirect_pc_out,
    output logic [ADDR_BITS-1:0]                  epc_out,
    output logic [1:0]                            cause_out,
    output logic [31:0]                           retired_cnt_out
);

    localparam int DQW = $clog2(Q_WIDTH+1);
    localparam int SLW = $clog2(Q_WIDTH);

    localparam logic [2:0] ST_DONE = 3'd1;
    localparam logic [2:0] ST_EXC  = 3'd2;
    localparam logic [2:0] ST_INT  = 3'd3;
    localparam logic [2:0] ST_TRAP = 3'd4;

    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

    state_t                 state_q, state_d;
    logic [DQW-1:0]         n_run;
    logic [Q_WIDTH-1:0]     mask_run;
    logic                   stv_run;
    logic [SLW-1:0]         slot_run;
    logic                   event_hit;
    logic [1:0]             event_cause;
    logic [ADDR_BITS-1:0]   event_pc;
    logic [ADDR_BITS-1:0]   vec_sel;
    logic                   stop;
    logic                   store_seen;
    logic [2:0]             status;

    // Scan oldest-first; the first slot that cannot retire ends the group and,
    // if it carries an event status, becomes the faulting entry.
    always_comb begin
        n_run       = '0;
        mask_run    = '0;
        stv_run     = 1'b0;
        slot_run    = '0;
        event_hit   = 1'b0;
        event_cause = 2'd0;
        event_pc    = '0;
        stop        = 1'b0;
        store_seen  = 1'b0;
        status      = '0;
        for (int unsigned i = 0; i < Q_WIDTH; i++) begin
            status = head_status_in[3*i +: 3];
            if (!stop) begin
                if (32'(rob_size_in) <= i) begin
                    stop = 1'b1;
                end else if (status == ST_DONE &&
                             !(head_is_store_in[i] && (store_seen || !st_commit_ready_in))) begin
                    n_run       = n_run + DQW'(1);
                    mask_run[i] = 1'b1;
                    if (head_is_store_in[i]) begin
                        store_seen = 1'b1;
                        stv_run    = 1'b1;
                        slot_run   = SLW'(i);
                    end
                end else begin
                    stop     = 1'b1;
                    event_pc = head_pc_in[ADDR_BITS*i +: ADDR_BITS];
                    case (status)
                        ST_EXC:  begin event_hit = 1'b1; event_cause = 2'd1; end
                        ST_INT:  begin event_hit = 1'b1; event_cause = 2'd2; end
                        ST_TRAP: begin event_hit = 1'b1; event_cause = 2'd3; end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        deq_out             = '0;
        commit_mask_out     = '0;
        st_commit_valid_out = 1'b0;
        st_commit_slot_out  = '0;
        case (state_q)
            RUN: begin
                deq_out             = n_run;
                commit_mask_out     = mask_run;
                st_commit_valid_out = stv_run;
                st_commit_slot_out  = slot_run;
                if (event_hit) state_d = FLUSH;
            end
            FLUSH:    state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        case (cause_out)
            2'd1:    vec_sel = EXC_VECTOR;
            2'd2:    vec_sel = INT_VECTOR;
            2'd3:    vec_sel = TRAP_VECTOR;
            default: vec_sel = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q            <= RUN;
            flush_out          <= 1'b0;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
            epc_out            <= '0;
            cause_out          <= 2'd0;
            retired_cnt_out    <= '0;
        end else begin
            state_q            <= state_d;
            flush_out          <= (state_d == FLUSH);
            redirect_valid_out <= (state_d == REDIRECT);
            redirect_pc_out    <= (state_d == REDIRECT) ? vec_sel : '0;
            if (state_q == RUN) begin
                retired_cnt_out <= retired_cnt_out + 32'(n_run);
                if (event_hit) begin
                    epc_out   <= event_pc;
                    cause_out <= event_cause;
                end
            end
        end
    end

endmodule
